// File: rtl/x2050dcc_if.sv
// Decimal result / condition-code sequencer bundle: sequencer inputs plus registered results.
// The master drives the microword command side; the slave is the sequencer.
interface x2050dcc_if #(
   parameter int CNT_W = 5
);
   logic             i_ros_advance;
   logic [2:0]       i_dcmd;
   logic [7:0]       i_result_byte;
   logic             i_carry_ovf;
   logic             i_r_sign_stat;
   logic             i_invalid_decimal_ss;
   logic             i_trap_ack;
   logic             o_busy;
   logic [CNT_W-1:0] o_byte_count;
   logic [3:0]       o_sign_nibble;
   logic [1:0]       o_cc;
   logic             o_cc_valid;
   logic             o_trap_req;

   modport master (
      output i_ros_advance, i_dcmd, i_result_byte, i_carry_ovf,
             i_r_sign_stat, i_invalid_decimal_ss, i_trap_ack,
      input  o_busy, o_byte_count, o_sign_nibble, o_cc, o_cc_valid, o_trap_req
   );

   modport slave (
      input  i_ros_advance, i_dcmd, i_result_byte, i_carry_ovf,
             i_r_sign_stat, i_invalid_decimal_ss, i_trap_ack,
      output o_busy, o_byte_count, o_sign_nibble, o_cc, o_cc_valid, o_trap_req
   );
endinterface

// File: rtl/x2050dcc.sv
// Packed-decimal result loop sequencer: sign nibble, condition code, data-exception trap; 1-cycle latency.
// No backpressure: commands act only on ROS advance, trap request holds until acknowledged.
module x2050dcc #(
   parameter int MAX_BYTES = 16,
   parameter int CNT_W     = 5
) (
   input  logic      i_clk,
   input  logic      i_reset,
   x2050dcc_if.slave dcc
);
   localparam logic [2:0] CMD_START  = 3'd1;
   localparam logic [2:0] CMD_ACCUM  = 3'd2;
   localparam logic [2:0] CMD_FINISH = 3'd3;
   localparam logic [2:0] CMD_ABORT  = 3'd4;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BYTES);
   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_BYTES + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             nz_q, nz_d;
   logic             ovf_q, ovf_d;
   logic [3:0]       sign_q, sign_d;
   logic [1:0]       cc_q, cc_d;
   logic             cc_vld_q, cc_vld_d;
   logic             trap_q, trap_d;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         nz_q     <= 1'b0;
         ovf_q    <= 1'b0;
         sign_q   <= 4'hc;
         cc_q     <= 2'd0;
         cc_vld_q <= 1'b0;
         trap_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         nz_q     <= nz_d;
         ovf_q    <= ovf_d;
         sign_q   <= sign_d;
         cc_q     <= cc_d;
         cc_vld_q <= cc_vld_d;
         trap_q   <= trap_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      nz_d     = nz_q;
      ovf_d    = ovf_q;
      sign_d   = sign_q;
      cc_d     = cc_q;
      cc_vld_d = 1'b0;
      // Ack is ungated; a fresh invalid strobe below wins over it.
      trap_d   = trap_q & ~dcc.i_trap_ack;

      if (dcc.i_ros_advance) begin
         if (dcc.i_invalid_decimal_ss)
            trap_d = 1'b1;

         if (dcc.i_invalid_decimal_ss && state_q == ST_ACCUM) begin
            // Data exception discards the operation, including any FINISH this cycle.
            state_d = ST_IDLE;
            nz_d    = 1'b0;
            ovf_d   = 1'b0;
         end else begin
            case (dcc.i_dcmd)
               CMD_START: begin
                  state_d = ST_ACCUM;
                  cnt_d   = '0;
                  nz_d    = 1'b0;
                  ovf_d   = 1'b0;
               end
               CMD_ACCUM: begin
                  if (state_q == ST_ACCUM) begin
                     nz_d  = nz_q | (dcc.i_result_byte != 8'h00);
                     ovf_d = ovf_q | dcc.i_carry_ovf | (cnt_q >= CNT_MAX);
                     if (cnt_q != CNT_SAT)
                        cnt_d = cnt_q + 1'b1;
                  end
               end
               CMD_FINISH: begin
                  if (state_q == ST_ACCUM) begin
                     state_d  = ST_DONE;
                     cc_vld_d = 1'b1;
                     if (ovf_q)
                        cc_d = 2'd3;
                     else if (!nz_q)
                        cc_d = 2'd0;
                     else if (dcc.i_r_sign_stat)
                        cc_d = 2'd1;
                     else
                        cc_d = 2'd2;
                     // Negative zero is reported with the positive sign.
                     sign_d = (dcc.i_r_sign_stat && (nz_q || ovf_q)) ? 4'hd : 4'hc;
                  end
               end
               CMD_ABORT: begin
                  state_d = ST_IDLE;
                  nz_d    = 1'b0;
                  ovf_d   = 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   assign dcc.o_busy        = (state_q == ST_ACCUM);
   assign dcc.o_byte_count  = cnt_q;
   assign dcc.o_sign_nibble = sign_q;
   assign dcc.o_cc          = cc_q;
   assign dcc.o_cc_valid    = cc_vld_q;
   assign dcc.o_trap_req    = trap_q;
endmodule

// File: tb/tb_x2050dcc.sv
// Bench for x2050dcc: directed scenarios with literal expectations, then random traffic vs a behavioural model.
module tb_x2050dcc;
   localparam int MAXB = 16;
   localparam logic [2:0] NOP = 3'd0, START = 3'd1, ACC = 3'd2, FIN = 3'd3, ABT = 3'd4;

   logic i_clk = 1'b0;
   logic i_reset = 1'b0;
   x2050dcc_if #(.CNT_W(5)) bus();

   x2050dcc #(.MAX_BYTES(MAXB), .CNT_W(5)) dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .dcc     (bus.slave)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Behavioural model: an operation is "open" between START and its FINISH/ABORT/exception.
   bit       m_open;
   int       m_cnt;
   bit       m_nz, m_ovf, m_ccv, m_trap;
   int       m_cc;
   int       m_sign;

   always @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         m_open = 0; m_cnt = 0; m_nz = 0; m_ovf = 0;
         m_ccv = 0; m_trap = 0; m_cc = 0; m_sign = 12;
      end else begin
         m_ccv = 0;
         if (bus.i_trap_ack) m_trap = 0;
         if (bus.i_ros_advance) begin
            if (bus.i_invalid_decimal_ss) m_trap = 1;
            if (bus.i_invalid_decimal_ss && m_open) begin
               m_open = 0; m_nz = 0; m_ovf = 0;
            end else if (bus.i_dcmd == START) begin
               m_open = 1; m_cnt = 0; m_nz = 0; m_ovf = 0;
            end else if (bus.i_dcmd == ACC && m_open) begin
               if (bus.i_result_byte != 0) m_nz = 1;
               if (bus.i_carry_ovf || m_cnt >= MAXB) m_ovf = 1;
               m_cnt = (m_cnt + 1 > MAXB + 1) ? MAXB + 1 : m_cnt + 1;
            end else if (bus.i_dcmd == FIN && m_open) begin
               m_open = 0;
               m_ccv  = 1;
               m_cc   = m_ovf ? 3 : !m_nz ? 0 : bus.i_r_sign_stat ? 1 : 2;
               m_sign = (bus.i_r_sign_stat && (m_nz || m_ovf)) ? 13 : 12;
            end else if (bus.i_dcmd == ABT) begin
               m_open = 0; m_nz = 0; m_ovf = 0;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge i_clk) begin
      if (chk_en && i_reset) begin
         chk("model busy",  32'(bus.o_busy),        32'(m_open));
         chk("model count", 32'(bus.o_byte_count),  32'(m_cnt));
         chk("model sign",  32'(bus.o_sign_nibble), 32'(m_sign));
         chk("model cc",    32'(bus.o_cc),          32'(m_cc));
         chk("model ccv",   32'(bus.o_cc_valid),    32'(m_ccv));
         chk("model trap",  32'(bus.o_trap_req),    32'(m_trap));
      end
   end

   task automatic step(input logic [2:0] c, input logic [7:0] b, input logic co,
                       input logic s, input logic inv, input logic ack, input logic adv);
      bus.i_dcmd = c; bus.i_result_byte = b; bus.i_carry_ovf = co;
      bus.i_r_sign_stat = s; bus.i_invalid_decimal_ss = inv;
      bus.i_trap_ack = ack; bus.i_ros_advance = adv;
      @(posedge i_clk);
      #1;
   endtask

   task automatic cmd(input logic [2:0] c);
      step(c, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask
   task automatic acc(input logic [7:0] b, input logic co);
      step(ACC, b, co, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask
   task automatic fin(input logic s);
      step(FIN, 8'h00, 1'b0, s, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      step(NOP, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(NOP, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("reset sign", 32'(bus.o_sign_nibble), 32'hc);
      chk("reset trap", 32'(bus.o_trap_req), 32'd0);
      #2 i_reset = 1'b1;
      chk_en = 1'b1;
      cmd(NOP);

      // Positive nonzero
      cmd(START);
      chk("start busy", 32'(bus.o_busy), 32'd1);
      acc(8'h00, 1'b0);
      acc(8'h12, 1'b0);
      fin(1'b0);
      chk("pos cc", 32'(bus.o_cc), 32'd2);
      chk("pos sign", 32'(bus.o_sign_nibble), 32'hc);
      chk("pos ccv", 32'(bus.o_cc_valid), 32'd1);
      chk("pos count", 32'(bus.o_byte_count), 32'd2);
      cmd(NOP);
      chk("pos ccv pulse", 32'(bus.o_cc_valid), 32'd0);

      // Negative zero
      cmd(START);
      for (int i = 0; i < 3; i++) acc(8'h00, 1'b0);
      fin(1'b1);
      chk("negzero cc", 32'(bus.o_cc), 32'd0);
      chk("negzero sign", 32'(bus.o_sign_nibble), 32'hc);

      // Byte overflow at MAX_BYTES+1
      cmd(START);
      for (int i = 0; i < MAXB + 1; i++) acc(8'h01, 1'b0);
      fin(1'b1);
      chk("ovf cc", 32'(bus.o_cc), 32'd3);
      chk("ovf sign", 32'(bus.o_sign_nibble), 32'hd);
      chk("ovf count", 32'(bus.o_byte_count), 32'd17);

      // Adder carry overflow on a zero byte, positive sign
      cmd(START);
      acc(8'h00, 1'b1);
      fin(1'b0);
      chk("carry cc", 32'(bus.o_cc), 32'd3);
      chk("carry sign", 32'(bus.o_sign_nibble), 32'hc);

      // Data exception together with FINISH
      cmd(START);
      acc(8'h05, 1'b0);
      step(FIN, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("dx trap", 32'(bus.o_trap_req), 32'd1);
      chk("dx ccv", 32'(bus.o_cc_valid), 32'd0);
      chk("dx cc held", 32'(bus.o_cc), 32'd3);
      chk("dx idle", 32'(bus.o_busy), 32'd0);
      step(NOP, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("ack+inv trap", 32'(bus.o_trap_req), 32'd1);
      step(NOP, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("ack trap", 32'(bus.o_trap_req), 32'd0);

      // Advance gating: nothing moves with advance low
      step(START, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(ACC, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(FIN, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("gate busy", 32'(bus.o_busy), 32'd0);
      chk("gate count", 32'(bus.o_byte_count), 32'd1);
      chk("gate cc", 32'(bus.o_cc), 32'd3);
      chk("gate trap", 32'(bus.o_trap_req), 32'd0);
      step(START, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(ACC, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(FIN, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("adv cc", 32'(bus.o_cc), 32'd1);
      chk("adv sign", 32'(bus.o_sign_nibble), 32'hd);
      chk("adv ccv", 32'(bus.o_cc_valid), 32'd1);

      // Randomized traffic, checked every cycle by the compare process
      for (int i = 0; i < 3000; i++) begin
         logic [2:0] c;
         logic [7:0] b;
         int r;
         r = $urandom_range(0, 99);
         c = (r < 45) ? ACC : (r < 60) ? START : (r < 75) ? FIN : (r < 80) ? ABT : 3'($urandom_range(0, 7));
         b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
         step(c, b, ($urandom_range(0, 19) == 0), 1'($urandom),
              ($urandom_range(0, 29) == 0), ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 9) != 0));
      end

      // Asynchronous reset mid-operation
      cmd(START);
      for (int i = 0; i < 3; i++) acc(8'h21, 1'b0);
      step(FIN, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      cmd(START);
      for (int i = 0; i < 3; i++) acc(8'h21, 1'b0);
      #2 i_reset = 1'b0;
      #1;
      chk("arst busy", 32'(bus.o_busy), 32'd0);
      chk("arst count", 32'(bus.o_byte_count), 32'd0);
      chk("arst sign", 32'(bus.o_sign_nibble), 32'hc);
      chk("arst cc", 32'(bus.o_cc), 32'd0);
      chk("arst ccv", 32'(bus.o_cc_valid), 32'd0);
      chk("arst trap", 32'(bus.o_trap_req), 32'd0);
      #3 i_reset = 1'b1;
      acc(8'h21, 1'b0);
      chk("arst ignores accum", 32'(bus.o_byte_count), 32'd0);
      cmd(NOP);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
